// File: rtl/hwpe_ctrl_parity_seq.sv
// hwpe_ctrl_parity_seq: serial even-parity sealer/checker for the HWPE control
// register file. A seal scans all IO and generic registers one word per cycle
// and writes their XOR into the parity word. A check scans the registers and
// the parity word and raises a sticky fault if the XOR is non-zero.
module hwpe_ctrl_parity_seq #(
    parameter int unsigned N_IO_REGS      = 4,
    parameter int unsigned N_GENERIC_REGS = 2,
    parameter int unsigned CHECK_PERIOD   = 1024,
    localparam int unsigned N_REGS        = N_IO_REGS + N_GENERIC_REGS,
    localparam int unsigned AW            = $clog2(N_REGS + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          seal_req_i,
    input  logic          check_req_i,
    input  logic          check_en_i,
    input  logic          wr_event_i,
    input  logic          clear_i,
    output logic [AW-1:0] rd_addr_o,
    input  logic [31:0]   rd_data_i,
    output logic          par_we_o,
    output logic [31:0]   par_data_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          fault_o
);

    localparam bit          PERIODIC = (CHECK_PERIOD > 0);
    localparam int unsigned RELOAD   = (CHECK_PERIOD > 0) ? CHECK_PERIOD - 1 : 0;
    localparam int unsigned CW       = (RELOAD > 0) ? $clog2(RELOAD + 1) : 1;

    localparam logic [AW-1:0] LAST_REG = AW'(N_REGS - 1);
    localparam logic [AW-1:0] PAR_IDX  = AW'(N_REGS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEAL_SCAN,
        ST_SEAL_WRITE,
        ST_CHK_SCAN,
        ST_CHK_EVAL
    } state_e;

    state_e        r_state;
    logic [AW-1:0] r_idx;
    logic [31:0]   r_acc;
    logic [31:0]   r_par_data;
    logic          r_par_we;
    logic          r_fault;
    logic          r_seal_pend;
    logic          r_chk_pend;
    logic [CW-1:0] r_cnt;
    logic          w_period_hit;

    assign w_period_hit = PERIODIC & check_en_i & (r_cnt == '0);

    // Periodic check timer: counts RELOAD..0 while enabled, reloads otherwise
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= CW'(RELOAD);
        end else if (!PERIODIC || !check_en_i || (r_cnt == '0)) begin
            r_cnt <= CW'(RELOAD);
        end else begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Scan sequencer: request latching, scan/accumulate, parity write, verdict
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_acc       <= '0;
            r_par_data  <= '0;
            r_par_we    <= 1'b0;
            r_fault     <= 1'b0;
            r_seal_pend <= 1'b0;
            r_chk_pend  <= 1'b0;
        end else begin
            r_par_we <= 1'b0;
            if (seal_req_i)                  r_seal_pend <= 1'b1;
            if (check_req_i || w_period_hit) r_chk_pend  <= 1'b1;
            if (clear_i)                     r_fault     <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    r_idx <= '0;
                    r_acc <= '0;
                    if (r_seal_pend || seal_req_i) begin
                        r_state     <= ST_SEAL_SCAN;
                        r_seal_pend <= 1'b0;
                    end else if (r_chk_pend || check_req_i) begin
                        r_state    <= ST_CHK_SCAN;
                        r_chk_pend <= 1'b0;
                    end
                end

                ST_SEAL_SCAN: begin
                    if (wr_event_i) begin
                        r_idx <= '0;
                        r_acc <= '0;
                    end else if (r_idx == LAST_REG) begin
                        // strobe and data are registered on entry so they are
                        // valid throughout the SEAL_WRITE cycle
                        r_state    <= ST_SEAL_WRITE;
                        r_par_we   <= 1'b1;
                        r_par_data <= r_acc ^ rd_data_i;
                        r_acc      <= r_acc ^ rd_data_i;
                        r_idx      <= '0;
                    end else begin
                        r_acc <= r_acc ^ rd_data_i;
                        r_idx <= r_idx + 1'b1;
                    end
                end

                ST_SEAL_WRITE: begin
                    r_state <= ST_IDLE;
                end

                ST_CHK_SCAN: begin
                    if (wr_event_i || seal_req_i) begin
                        r_state <= ST_IDLE;
                        r_idx   <= '0;
                    end else if (r_idx == PAR_IDX) begin
                        r_state <= ST_CHK_EVAL;
                        r_acc   <= r_acc ^ rd_data_i;
                        r_idx   <= '0;
                    end else begin
                        r_acc <= r_acc ^ rd_data_i;
                        r_idx <= r_idx + 1'b1;
                    end
                end

                ST_CHK_EVAL: begin
                    if (!wr_event_i && (r_acc != '0)) r_fault <= 1'b1;
                    r_state <= ST_IDLE;
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // done_o must be suppressed by a write landing in CHK_EVAL itself, so it
    // is decoded from the state register rather than registered ahead of time
    assign done_o     = (r_state == ST_SEAL_WRITE) ||
                        ((r_state == ST_CHK_EVAL) && !wr_event_i);
    assign busy_o     = (r_state != ST_IDLE);
    assign rd_addr_o  = r_idx;
    assign par_we_o   = r_par_we;
    assign par_data_o = r_par_data;
    assign fault_o    = r_fault;

endmodule

// File: tb/tb_hwpe_ctrl_parity_seq.sv
// Self-checking bench for hwpe_ctrl_parity_seq with a 4 IO + 2 generic
// register file modelled as an array; the parity word lives at index 6.
module tb_hwpe_ctrl_parity_seq;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        seal_req_i, check_req_i, check_en_i, wr_event_i, clear_i;
    logic [2:0]  rd_addr_o;
    logic [31:0] rd_data_i;
    logic        par_we_o;
    logic [31:0] par_data_o;
    logic        busy_o, done_o, fault_o;

    logic [31:0] regs [0:7];
    int          checks = 0;
    int          errors = 0;

    hwpe_ctrl_parity_seq #(
        .N_IO_REGS     (4),
        .N_GENERIC_REGS(2),
        .CHECK_PERIOD  (16)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .seal_req_i (seal_req_i),
        .check_req_i(check_req_i),
        .check_en_i (check_en_i),
        .wr_event_i (wr_event_i),
        .clear_i    (clear_i),
        .rd_addr_o  (rd_addr_o),
        .rd_data_i  (rd_data_i),
        .par_we_o   (par_we_o),
        .par_data_o (par_data_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .fault_o    (fault_o)
    );

    always #5 clk = ~clk;

    // combinational register file read port
    always_comb rd_data_i = regs[rd_addr_o];

    // XOR of the first n words of the modelled register file
    function automatic logic [31:0] xor_regs(input int n);
        logic [31:0] x = '0;
        for (int i = 0; i < n; i++) x ^= regs[i];
        return x;
    endfunction

    // one clock; the register file takes the parity write at the edge
    task automatic tick();
        logic        we;
        logic [31:0] d;
        we = par_we_o;
        d  = par_data_o;
        @(posedge clk);
        #1;
        if (we) regs[6] = d;
    endtask

    task automatic randomize_regs();
        for (int i = 0; i < 6; i++) regs[i] = $urandom;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (3) tick();
        checks++; if (busy_o !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b exp 0", busy_o); end
        checks++; if (par_we_o !== 1'b0)   begin errors++; $display("FAIL reset_par_we got %b exp 0", par_we_o); end
        checks++; if (par_data_o !== '0)   begin errors++; $display("FAIL reset_par_data got %h exp 0", par_data_o); end
        checks++; if (rd_addr_o !== '0)    begin errors++; $display("FAIL reset_rd_addr got %0d exp 0", rd_addr_o); end
        checks++; if (done_o !== 1'b0)     begin errors++; $display("FAIL reset_done got %b exp 0", done_o); end
        checks++; if (fault_o !== 1'b0)    begin errors++; $display("FAIL reset_fault got %b exp 0", fault_o); end
        rst_ni = 1'b1;
        tick();
        checks++; if (busy_o !== 1'b0)     begin errors++; $display("FAIL post_reset_busy got %b exp 0", busy_o); end
    endtask

    task automatic test_seal();
        regs[0] = 1; regs[1] = 2; regs[2] = 4; regs[3] = 8; regs[4] = 16; regs[5] = 32;
        regs[6] = 0;
        seal_req_i = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 1) seal_req_i = 1'b0;
            checks++; if (par_we_o !== (k == 7))          begin errors++; $display("FAIL seal_we k=%0d got %b exp %b", k, par_we_o, k == 7); end
            checks++; if (done_o !== (k == 7))            begin errors++; $display("FAIL seal_done k=%0d got %b exp %b", k, done_o, k == 7); end
            checks++; if (busy_o !== (k <= 7))            begin errors++; $display("FAIL seal_busy k=%0d got %b exp %b", k, busy_o, k <= 7); end
            if (k == 7) begin
                checks++; if (par_data_o !== 32'h3F)      begin errors++; $display("FAIL seal_data got %h exp 3f", par_data_o); end
            end
        end
        checks++; if (par_data_o !== 32'h3F)              begin errors++; $display("FAIL seal_data_hold got %h exp 3f", par_data_o); end
    endtask

    // corrupt=1 flips bit 5 of reg 2 behind the sequencer's back
    task automatic test_check(input bit corrupt);
        logic exp_fault;
        if (corrupt) regs[2] ^= 32'h20;
        exp_fault = (xor_regs(7) != 0);
        check_req_i = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 1) check_req_i = 1'b0;
            checks++; if (done_o !== (k == 8))  begin errors++; $display("FAIL check_done c=%0d k=%0d got %b exp %b", corrupt, k, done_o, k == 8); end
            checks++; if (busy_o !== (k <= 8))  begin errors++; $display("FAIL check_busy c=%0d k=%0d got %b exp %b", corrupt, k, busy_o, k <= 8); end
            checks++; if (fault_o !== (k == 9 ? exp_fault : 1'b0))
                begin errors++; $display("FAIL check_fault c=%0d k=%0d got %b exp %b", corrupt, k, fault_o, k == 9 ? exp_fault : 1'b0); end
        end
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        checks++; if (fault_o !== 1'b0) begin errors++; $display("FAIL check_clear got %b exp 0", fault_o); end
        if (corrupt) regs[2] ^= 32'h20;
    endtask

    task automatic test_seal_restart();
        logic [31:0] newval;
        logic [31:0] exp;
        randomize_regs();
        newval = $urandom;
        exp = '0;
        seal_req_i = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 1) seal_req_i = 1'b0;
            if (k == 4) begin
                wr_event_i = 1'b0;
                regs[4] = newval;
                exp = xor_regs(6);
            end
            if (k == 3) wr_event_i = 1'b1;
            checks++; if (par_we_o !== (k == 10)) begin errors++; $display("FAIL restart_we k=%0d got %b exp %b", k, par_we_o, k == 10); end
            checks++; if (done_o !== (k == 10))   begin errors++; $display("FAIL restart_done k=%0d got %b exp %b", k, done_o, k == 10); end
            if (k == 10) begin
                checks++; if (par_data_o !== exp) begin errors++; $display("FAIL restart_data got %h exp %h", par_data_o, exp); end
            end
        end
    endtask

    task automatic test_seal_aborts_check();
        logic [31:0] exp;
        randomize_regs();
        exp = xor_regs(6);
        check_req_i = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            tick();
            if (k == 1) check_req_i = 1'b0;
            if (k == 4) seal_req_i = 1'b0;
            if (k == 3) seal_req_i = 1'b1;
            checks++; if (busy_o !== (k <= 3 || (k >= 5 && k <= 11)))
                begin errors++; $display("FAIL abort_busy k=%0d got %b exp %b", k, busy_o, k <= 3 || (k >= 5 && k <= 11)); end
            checks++; if (done_o !== (k == 11))   begin errors++; $display("FAIL abort_done k=%0d got %b exp %b", k, done_o, k == 11); end
            checks++; if (par_we_o !== (k == 11)) begin errors++; $display("FAIL abort_we k=%0d got %b exp %b", k, par_we_o, k == 11); end
            checks++; if (fault_o !== 1'b0)       begin errors++; $display("FAIL abort_fault k=%0d got %b exp 0", k, fault_o); end
            if (k == 11) begin
                checks++; if (par_data_o !== exp) begin errors++; $display("FAIL abort_data got %h exp %h", par_data_o, exp); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        randomize_regs();
        exp = xor_regs(6);
        seal_req_i = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick();
            seal_req_i = (k == 3 || k == 5);
            checks++; if (par_we_o !== (k == 7 || k == 15))
                begin errors++; $display("FAIL b2b_we k=%0d got %b exp %b", k, par_we_o, k == 7 || k == 15); end
            checks++; if (busy_o !== (k != 8 && k <= 15))
                begin errors++; $display("FAIL b2b_busy k=%0d got %b exp %b", k, busy_o, k != 8 && k <= 15); end
            if (k == 7 || k == 15) begin
                checks++; if (par_data_o !== exp) begin errors++; $display("FAIL b2b_data k=%0d got %h exp %h", k, par_data_o, exp); end
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            logic [31:0] exp;
            logic        exp_fault;
            int          lat;
            randomize_regs();
            exp = xor_regs(6);
            lat = 0;
            seal_req_i = 1'b1;
            do begin
                tick();
                lat++;
                seal_req_i = 1'b0;
            end while (!par_we_o && lat < 20);
            checks++; if (!par_we_o || lat != 7) begin errors++; $display("FAIL rnd_seal_lat it=%0d got %0d exp 7", it, lat); end
            checks++; if (par_data_o !== exp)    begin errors++; $display("FAIL rnd_seal_data it=%0d got %h exp %h", it, par_data_o, exp); end
            tick();
            if ($urandom_range(0, 1) == 1)
                regs[$urandom_range(0, 6)] ^= (32'h1 << $urandom_range(0, 31));
            exp_fault = (xor_regs(7) != 0);
            check_req_i = 1'b1;
            for (int k = 1; k <= 9; k++) begin
                tick();
                check_req_i = 1'b0;
                if (k == 8) begin
                    checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL rnd_check_done it=%0d got %b exp 1", it, done_o); end
                end
            end
            checks++; if (fault_o !== exp_fault) begin errors++; $display("FAIL rnd_check_fault it=%0d got %b exp %b", it, fault_o, exp_fault); end
            clear_i = 1'b1;
            tick();
            clear_i = 1'b0;
        end
    endtask

    task automatic test_periodic();
        int  ph;
        logic exp_fault;
        seal_req_i = 1'b1;
        tick();
        seal_req_i = 1'b0;
        repeat (8) tick();
        check_en_i = 1'b1;
        for (int k = 1; k <= 74; k++) begin
            tick();
            clear_i = (k == 58 || k == 72);
            if (k == 41) regs[$urandom_range(0, 5)] ^= (32'h1 << $urandom_range(0, 31));
            ph = (k - 17) % 16;
            exp_fault = (k >= 57 && k <= 58) || (k >= 73);
            checks++; if (busy_o !== (k >= 17 && ph < 8))
                begin errors++; $display("FAIL per_busy k=%0d got %b exp %b", k, busy_o, k >= 17 && ph < 8); end
            checks++; if (done_o !== (k >= 17 && ph == 7))
                begin errors++; $display("FAIL per_done k=%0d got %b exp %b", k, done_o, k >= 17 && ph == 7); end
            checks++; if (fault_o !== exp_fault)
                begin errors++; $display("FAIL per_fault k=%0d got %b exp %b", k, fault_o, exp_fault); end
        end
        clear_i = 1'b0;
        check_en_i = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_seal();
        randomize_regs();
        seal_req_i = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            seal_req_i = 1'b0;
        end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL rst_mid_pre_busy got %b exp 1", busy_o); end
        rst_ni = 1'b0;
        #1;
        checks++; if (busy_o !== 1'b0)   begin errors++; $display("FAIL rst_mid_busy got %b exp 0", busy_o); end
        checks++; if (rd_addr_o !== '0)  begin errors++; $display("FAIL rst_mid_addr got %0d exp 0", rd_addr_o); end
        checks++; if (fault_o !== 1'b0)  begin errors++; $display("FAIL rst_mid_fault got %b exp 0", fault_o); end
        checks++; if (par_data_o !== '0) begin errors++; $display("FAIL rst_mid_data got %h exp 0", par_data_o); end
        checks++; if (done_o !== 1'b0)   begin errors++; $display("FAIL rst_mid_done got %b exp 0", done_o); end
        repeat (2) tick();
        rst_ni = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            checks++; if (par_we_o !== 1'b0) begin errors++; $display("FAIL rst_post_we k=%0d got %b exp 0", k, par_we_o); end
            checks++; if (busy_o !== 1'b0)   begin errors++; $display("FAIL rst_post_busy k=%0d got %b exp 0", k, busy_o); end
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) regs[i] = '0;
        seal_req_i  = 1'b0;
        check_req_i = 1'b0;
        check_en_i  = 1'b0;
        wr_event_i  = 1'b0;
        clear_i     = 1'b0;
        test_reset();
        test_seal();
        test_check(1'b0);
        test_check(1'b1);
        test_seal_restart();
        test_seal_aborts_check();
        test_back_to_back();
        test_random();
        test_periodic();
        test_reset_mid_seal();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
